// File: rtl/lut7_cfg_pkg.sv
// Shared constants and FSM state type for the reconfigurable LUT7.
// Build option: define LUT7_CFG_SHADOW_EN for double-buffered loads.
package lut7_cfg_pkg;

  localparam int LUT_BITS = 128;
  localparam int CNT_W    = 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LUT_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } lut7_cfg_state_t;

endpackage

// File: rtl/lut7_cfg_if.sv
// Load/lookup bus of lut7_cfg; master drives stimulus, slave is the LUT.
interface lut7_cfg_if;

  logic LOAD_START;
  logic CE;
  logic CDI;
  logic CDO;
  logic I0, I1, I2, I3, I4, I5, I6;
  logic QCE;
  logic F;
  logic Q;
  logic BUSY;
  logic DONE;

  modport master (
    output LOAD_START, CE, CDI, I0, I1, I2, I3, I4, I5, I6, QCE,
    input  CDO, F, Q, BUSY, DONE
  );

  modport slave (
    input  LOAD_START, CE, CDI, I0, I1, I2, I3, I4, I5, I6, QCE,
    output CDO, F, Q, BUSY, DONE
  );

endinterface

// File: rtl/lut7_cfg_ctrl.sv
// Serial load controller: IDLE/LOAD/DONE FSM, 7-bit bit counter and strobes.
// shift_en marks accepted bits 1..127, commit marks the accepted 128th bit.
module lut7_cfg_ctrl
  import lut7_cfg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_start,
  input  logic ce,
  output logic busy,
  output logic done,
  output logic shift_en,
  output logic commit
);

  lut7_cfg_state_t  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A LOAD_START inside LOAD restarts the count and swallows that cycle's bit.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (load_start) begin
          count_d = '0;
        end else if (ce) begin
          if (count_q == CNT_LAST) begin
            commit  = 1'b1;
            state_d = DONE;
            count_d = '0;
          end else begin
            shift_en = 1'b1;
            count_d  = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        count_d = '0;
        state_d = load_start ? LOAD : IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy = (state_q == LOAD);
  assign done = (state_q == DONE);

endmodule

// File: rtl/lut7_cfg.sv
// Run-time reconfigurable LUT7: table registers, 128:1 lookup and Q register.
// LUT7_CFG_SHADOW_EN selects a shadow-buffered load; otherwise active shifts directly.
module lut7_cfg
  import lut7_cfg_pkg::*;
#(
  parameter logic [LUT_BITS-1:0] INIT = '0
) (
  input  logic        CLK,
  input  logic        CLEAR,
  lut7_cfg_if.slave   bus
);

  logic                shift_en;
  logic                commit;
  logic [CNT_W-1:0]    idx;
  logic                f;
  logic [LUT_BITS-1:0] active_q, active_d;
  logic                q_q, q_d;

  lut7_cfg_ctrl u_ctrl (
    .clk        (CLK),
    .rst        (CLEAR),
    .load_start (bus.LOAD_START),
    .ce         (bus.CE),
    .busy       (bus.BUSY),
    .done       (bus.DONE),
    .shift_en   (shift_en),
    .commit     (commit)
  );

  assign idx = {bus.I6, bus.I5, bus.I4, bus.I3, bus.I2, bus.I1, bus.I0};
  assign f   = active_q[idx];

`ifdef LUT7_CFG_SHADOW_EN
  logic [LUT_BITS-1:0] shadow_q, shadow_d;

  // Commit takes the final bit straight from CDI so active matches the full shift.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (shift_en || commit) begin
      shadow_d = {shadow_q[LUT_BITS-2:0], bus.CDI};
    end
    if (commit) begin
      active_d = {shadow_q[LUT_BITS-2:0], bus.CDI};
    end
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign bus.CDO = shadow_q[LUT_BITS-1];
`else
  always_comb begin
    active_d = active_q;
    if (shift_en || commit) begin
      active_d = {active_q[LUT_BITS-2:0], bus.CDI};
    end
  end

  assign bus.CDO = active_q[LUT_BITS-1];
`endif

  always_comb begin
    q_d = bus.QCE ? f : q_q;
  end

  always_ff @(posedge CLK or posedge CLEAR) begin
    if (CLEAR) begin
      active_q <= INIT;
      q_q      <= 1'b0;
    end else begin
      active_q <= active_d;
      q_q      <= q_d;
    end
  end

  assign bus.F = f;
  assign bus.Q = q_q;

endmodule

// File: tb/tb_lut7_cfg.sv
// Self-checking bench for lut7_cfg: reset vectors, directed load sequences,
// async CLEAR, Q register behaviour and a randomized run against a table model.
`timescale 1ns/1ps
module tb_lut7_cfg;

  localparam logic [127:0] INIT_VAL = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  logic CLK   = 1'b0;
  logic CLEAR = 1'b1;

  lut7_cfg_if bus ();

  lut7_cfg #(.INIT(INIT_VAL)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: whole tables as 128-bit values plus a count of accepted bits.
  logic [127:0] mActive;
  logic [127:0] mShadow;
  bit           mLoading;
  int           mCnt;
  bit           mDone;
  bit           mQ;
  bit [6:0]     curIdx;

  typedef struct {
    bit [6:0] idx;
    bit       f;
  } vec_t;

  vec_t resetVec[6];

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic modelCdo();
`ifdef LUT7_CFG_SHADOW_EN
    return mShadow[127];
`else
    return mActive[127];
`endif
  endfunction

  task automatic modelReset();
    mActive  = INIT_VAL;
    mShadow  = '0;
    mLoading = 1'b0;
    mCnt     = 0;
    mDone    = 1'b0;
    mQ       = 1'b0;
  endtask

  task automatic modelEdge(input bit ls, input bit ce, input bit cdi, input bit qce,
                           input bit [6:0] idx);
    if (CLEAR) begin
      modelReset();
      return;
    end
    if (qce) mQ = mActive[idx];
    mDone = 1'b0;
    if (mLoading) begin
      if (ls) begin
        mCnt = 0;
      end else if (ce) begin
`ifdef LUT7_CFG_SHADOW_EN
        mShadow = {mShadow[126:0], cdi};
`else
        mActive = {mActive[126:0], cdi};
`endif
        mCnt++;
        if (mCnt == 128) begin
`ifdef LUT7_CFG_SHADOW_EN
          mActive = mShadow;
`endif
          mLoading = 1'b0;
          mDone    = 1'b1;
          mCnt     = 0;
        end
      end
    end else if (ls) begin
      mLoading = 1'b1;
      mCnt     = 0;
    end
  endtask

  task automatic setInputs(input bit ls, input bit ce, input bit cdi, input bit qce,
                           input bit [6:0] idx);
    bus.LOAD_START = ls;
    bus.CE         = ce;
    bus.CDI        = cdi;
    bus.QCE        = qce;
    bus.I0 = idx[0]; bus.I1 = idx[1]; bus.I2 = idx[2]; bus.I3 = idx[3];
    bus.I4 = idx[4]; bus.I5 = idx[5]; bus.I6 = idx[6];
    curIdx = idx;
  endtask

  task automatic checkOutput(input string name);
    check1({name, ".F"},    bus.F,    mActive[curIdx]);
    check1({name, ".Q"},    bus.Q,    mQ);
    check1({name, ".BUSY"}, bus.BUSY, mLoading);
    check1({name, ".DONE"}, bus.DONE, mDone);
    check1({name, ".CDO"},  bus.CDO,  modelCdo());
  endtask

  // One clock cycle: drive, take the edge in DUT and model, sample 1ns later.
  task automatic applyStimulus(input string name, input bit ls, input bit ce, input bit cdi,
                               input bit qce, input bit [6:0] idx);
    setInputs(ls, ce, cdi, qce, idx);
    @(posedge CLK);
    modelEdge(ls, ce, cdi, qce, idx);
    #1;
    checkOutput(name);
  endtask

  // Walk every address while idle and compare F against a literal table too.
  task automatic sweepF(input string name, input logic [127:0] expTable);
    for (int i = 0; i < 128; i++) begin
      applyStimulus(name, 1'b0, 1'b0, 1'b0, 1'b0, 7'(i));
      check1({name, ".table"}, bus.F, expTable[i]);
    end
  endtask

  // Full 128-bit load, MSB first; gap cycles of CE low are inserted after gapAfter bits.
  task automatic loadTable(input string name, input logic [127:0] value,
                           input int gapAfter, input int gapLen);
    applyStimulus(name, 1'b1, 1'b0, 1'b0, 1'b0, 7'($urandom_range(127)));
    for (int k = 0; k < 128; k++) begin
      if (k == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          applyStimulus(name, 1'b0, 1'b0, 1'($urandom), 1'b0, 7'($urandom_range(127)));
          check1({name, ".gapBusy"}, bus.BUSY, 1'b1);
        end
      end
      applyStimulus(name, 1'b0, 1'b1, value[127-k], 1'b0, 7'($urandom_range(127)));
    end
    check1({name, ".done"}, bus.DONE, 1'b1);
    check1({name, ".busyOff"}, bus.BUSY, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] rnd;
    resetVec[0] = '{7'd0,   1'b1};
    resetVec[1] = '{7'd1,   1'b0};
    resetVec[2] = '{7'd63,  1'b0};
    resetVec[3] = '{7'd64,  1'b0};
    resetVec[4] = '{7'd126, 1'b0};
    resetVec[5] = '{7'd127, 1'b1};

    setInputs(1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    modelReset();

    // Held in reset: INIT visible on F, edges with QCE/LOAD_START have no effect.
    foreach (resetVec[v]) begin
      applyStimulus("reset", 1'b1, 1'b1, 1'b1, 1'b1, resetVec[v].idx);
      check1("resetVec.F", bus.F, resetVec[v].f);
      check1("resetVec.Q", bus.Q, 1'b0);
      check1("resetVec.BUSY", bus.BUSY, 1'b0);
    end
    #2;
    CLEAR = 1'b0;
    sweepF("initSweep", INIT_VAL);

    // All ones, CE held high.
    loadTable("ones", {128{1'b1}}, 200, 0);
    sweepF("onesSweep", {128{1'b1}});

    // Single bit at entry 1, with a 10-cycle CE gap after bit 60.
    loadTable("gap", 128'h2, 60, 10);
    sweepF("gapSweep", 128'h2);

    // Restart after 64 bits, then load all zeros.
    applyStimulus("restart", 1'b1, 1'b0, 1'b0, 1'b0, 7'd1);
    for (int k = 0; k < 64; k++)
      applyStimulus("restart", 1'b0, 1'b1, 1'($urandom), 1'b0, 7'($urandom_range(127)));
    loadTable("zeros", 128'h0, 200, 0);
    sweepF("zeroSweep", 128'h0);

    // CLEAR mid-load takes effect without a clock edge.
    applyStimulus("clr", 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    for (int k = 0; k < 64; k++)
      applyStimulus("clr", 1'b0, 1'b1, 1'($urandom), 1'b0, 7'd0);
    #2;
    CLEAR = 1'b1;
    modelReset();
    #1;
    checkOutput("clrAsync");
    check1("clrAsync.Finit", bus.F, 1'b1);
    #2;
    CLEAR = 1'b0;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    loadTable("afterClr", rnd, 200, 0);
    sweepF("afterClrSweep", rnd);

    // Q follows F with one edge lag under QCE, then holds.
    for (int k = 0; k < 12; k++)
      applyStimulus("qce1", 1'b0, 1'b0, 1'b0, 1'b1, 7'($urandom_range(127)));
    for (int k = 0; k < 12; k++)
      applyStimulus("qce0", 1'b0, 1'b0, 1'b0, 1'b0, 7'($urandom_range(127)));

    // Randomized traffic: restarts are rare during a load so commits still happen.
    for (int c = 0; c < 3000; c++) begin
      bit ls;
      ls = mLoading ? ($urandom_range(399) == 0) : ($urandom_range(7) == 0);
      applyStimulus("rand", ls, ($urandom_range(3) != 0), 1'($urandom),
                    1'($urandom), 7'($urandom_range(127)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
